// File: rtl/ldl_round_mux_pkg.sv
// Shared types for the LDL_round arbiter family.
// State encoding plus a lane slicer for flattened payload buses.
package ldl_round_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_e;

  localparam int SLICE_MAX = 1024;

  // Caller truncates the result to its lane width.
  function automatic logic [SLICE_MAX-1:0] slice(
    input logic [SLICE_MAX-1:0] bus,
    input int unsigned          idx,
    input int unsigned          dw
  );
    return bus >> (idx * dw);
  endfunction

endpackage

// File: rtl/ldl_round_mux_if.sv
// Stream, arbiter and output bundle for ldl_round_mux.
// master is the mux side, slave is the surrounding fabric.
interface ldl_round_mux_if #(
  parameter int BIN_WIDTH  = 3,
  parameter int DATA_WIDTH = 8
);

  localparam int REQ_WIDTH = 1 << BIN_WIDTH;

  logic [REQ_WIDTH-1:0]            in_valid;
  logic [REQ_WIDTH*DATA_WIDTH-1:0] in_data;
  logic [REQ_WIDTH-1:0]            in_last;
  logic [REQ_WIDTH-1:0]            in_ready;
  logic [REQ_WIDTH-1:0]            arb_req;
  logic                            arb_ack;
  logic [BIN_WIDTH-1:0]            arb_bin;
  logic [REQ_WIDTH-1:0]            arb_hot;
  logic                            out_valid;
  logic [DATA_WIDTH-1:0]           out_data;
  logic                            out_last;
  logic [BIN_WIDTH-1:0]            out_src;
  logic                            out_ready;
  logic                            err;

  modport master (
    input  in_valid, in_data, in_last,
    input  arb_ack, arb_bin, arb_hot,
    input  out_ready,
    output in_ready, arb_req,
    output out_valid, out_data, out_last,
    output out_src, err
  );

  modport slave (
    output in_valid, in_data, in_last,
    output arb_ack, arb_bin, arb_hot,
    output out_ready,
    input  in_ready, arb_req,
    input  out_valid, out_data, out_last,
    input  out_src, err
  );

endinterface

// File: rtl/ldl_round_mux_oreg.sv
// One-deep registered pipe stage with valid/ready.
// Accepts a new word whenever empty or being drained.
module ldl_round_oreg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  input  logic         ready_i,
  output logic         load_o,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  assign load_o  = ~valid_q | ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (valid_i && load_o) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/ldl_round_mux.sv
// Packet-aware N:1 stream mux behind the LDL_round arbiter.
// Grant is locked per packet; the last beat releases it.
module ldl_round_mux
  import ldl_round_pkg::*;
#(
  parameter  int BIN_WIDTH  = 3,
  parameter  int DATA_WIDTH = 8,
  localparam int REQ_WIDTH  = 1 << BIN_WIDTH
) (
  input logic           clk,
  input logic           rst,
  ldl_round_mux_if.master bus
);

  localparam int PW = DATA_WIDTH + 1 + BIN_WIDTH;

  state_e               state_q, state_d;
  logic [BIN_WIDTH-1:0] sel_q, sel_d;
  logic                 err_q, err_d;

  logic                  load;
  logic                  xfer;
  logic                  chan_valid;
  logic                  chan_last;
  logic [DATA_WIDTH-1:0] chan_data;
  logic [REQ_WIDTH-1:0]  hot_exp;
  logic                  bad_hot;
  logic                  bad_ack;
  logic [PW-1:0]         pay_in;
  logic [PW-1:0]         pay_out;
  logic                  ovalid;

  assign chan_valid = bus.in_valid[sel_q];
  assign chan_last  = bus.in_last[sel_q];
  assign chan_data  = DATA_WIDTH'(slice(
    SLICE_MAX'(bus.in_data), 32'(sel_q), 32'(DATA_WIDTH)));

  assign hot_exp = REQ_WIDTH'(1) << bus.arb_bin;
  assign bad_hot = bus.arb_ack & (bus.arb_hot != hot_exp);
  assign bad_ack = (state_q == IDLE) & bus.arb_ack
                 & ~bus.in_valid[bus.arb_bin];
  assign err_d   = err_q | bad_hot | bad_ack;

  // in_ready is held low in reset so no beat is lost to the flush.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    bus.arb_req  = '0;
    bus.in_ready = '0;
    xfer         = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.arb_req = bus.in_valid;
        if (bus.arb_ack && bus.in_valid[bus.arb_bin]) begin
          sel_d   = bus.arb_bin;
          state_d = XFER;
        end
      end
      XFER: begin
        bus.in_ready[sel_q] = load & ~rst;
        xfer = chan_valid & load & ~rst;
        if (xfer && chan_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
    end
  end

  assign pay_in = {chan_data, chan_last, sel_q};

  ldl_round_oreg #(
    .W (PW)
  ) u_oreg (
    .clk     (clk),
    .rst     (rst),
    .valid_i (xfer),
    .data_i  (pay_in),
    .ready_i (bus.out_ready),
    .load_o  (load),
    .valid_o (ovalid),
    .data_o  (pay_out)
  );

  assign bus.out_valid = ovalid;
  assign bus.out_data  = pay_out[PW-1 -: DATA_WIDTH];
  assign bus.out_last  = pay_out[BIN_WIDTH];
  assign bus.out_src   = pay_out[BIN_WIDTH-1:0];
  assign bus.err       = err_q;

endmodule

// File: tb/tb_ldl_round_mux.sv
// Directed bench for ldl_round_mux with a hand-driven arbiter
// and an upstream packet source that honours the hold rule.
module tb_ldl_round_mux;

  localparam int BW = 3;
  localparam int DW = 8;
  localparam int RW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ldl_round_mux_if #(.BIN_WIDTH(BW), .DATA_WIDTH(DW)) bus ();

  ldl_round_mux #(
    .BIN_WIDTH  (BW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int         bidx  [RW];
  int         plen  [RW];
  logic [7:0] pbase [RW];
  bit         act   [RW];

  logic [7:0] got_d [$];
  logic       got_l [$];
  logic [2:0] got_s [$];
  int         got_c [$];

  task automatic drive_up();
    for (int c = 0; c < RW; c++) begin
      bus.in_valid[c] = act[c];
      bus.in_data[c*DW +: DW] = act[c] ? pbase[c] + 8'(bidx[c]) : 8'h00;
      bus.in_last[c] = act[c] && (bidx[c] == plen[c] - 1);
    end
  endtask

  task automatic tick();
    logic [RW-1:0] acc;
    acc = bus.in_ready & bus.in_valid;
    if (bus.out_valid && bus.out_ready) begin
      got_d.push_back(bus.out_data);
      got_l.push_back(bus.out_last);
      got_s.push_back(bus.out_src);
      got_c.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int c = 0; c < RW; c++) begin
      if (acc[c]) begin
        if (bidx[c] == plen[c] - 1) act[c] = 1'b0;
        bidx[c]++;
      end
    end
    drive_up();
    #1;
  endtask

  task automatic start_pkt(input int c, input int n, input logic [7:0] b);
    act[c]   = 1'b1;
    bidx[c]  = 0;
    plen[c]  = n;
    pbase[c] = b;
  endtask

  task automatic grant(input int b, input logic [7:0] hot);
    bus.arb_ack = 1'b1;
    bus.arb_bin = 3'(b);
    bus.arb_hot = hot;
    #1;
    tick();
    bus.arb_ack = 1'b0;
    bus.arb_bin = '0;
    bus.arb_hot = '0;
    #1;
  endtask

  task automatic clear_got();
    got_d.delete();
    got_l.delete();
    got_s.delete();
    got_c.delete();
  endtask

  task automatic run_until_done(input int c);
    int n;
    n = 0;
    while (act[c] && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (act[c]) begin
      errors++;
      $display("FAIL timeout_ch%0d got pending exp done", c);
    end
    repeat (3) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      bus.in_valid  = 8'($urandom);
      bus.in_data   = {$urandom, $urandom};
      bus.in_last   = 8'($urandom);
      bus.arb_ack   = 1'($urandom_range(0, 1));
      bus.arb_bin   = 3'($urandom);
      bus.arb_hot   = 8'($urandom);
      bus.out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL rst_out_valid got %b exp 0", bus.out_valid);
      end
      checks++;
      if (bus.in_ready !== 8'h00) begin
        errors++;
        $display("FAIL rst_in_ready got %h exp 00", bus.in_ready);
      end
      checks++;
      if (bus.err !== 1'b0) begin
        errors++;
        $display("FAIL rst_err got %b exp 0", bus.err);
      end
    end
    rst = 1'b0;
    bus.arb_ack   = 1'b0;
    bus.arb_bin   = '0;
    bus.arb_hot   = '0;
    bus.out_ready = 1'b1;
    bus.in_data   = '0;
    bus.in_last   = '0;
    bus.in_valid  = 8'h3c;
    #1;
    checks++;
    if (bus.arb_req !== 8'h3c) begin
      errors++;
      $display("FAIL rel_arb_req got %h exp 3c", bus.arb_req);
    end
    checks++;
    if ({bus.out_data, bus.out_src, bus.out_last} !== 12'h000) begin
      errors++;
      $display("FAIL rel_out got %h/%h/%b exp 0",
               bus.out_data, bus.out_src, bus.out_last);
    end
    checks++;
    if (bus.in_ready !== 8'h00) begin
      errors++;
      $display("FAIL rel_in_ready got %h exp 00", bus.in_ready);
    end
    for (int c = 0; c < RW; c++) act[c] = 1'b0;
    drive_up();
    #1;
  endtask

  task automatic test_single();
    start_pkt(2, 4, 8'h10);
    drive_up();
    #1;
    checks++;
    if (bus.arb_req !== 8'h04) begin
      errors++;
      $display("FAIL single_req got %h exp 04", bus.arb_req);
    end
    grant(2, 8'h04);
    checks++;
    if (bus.in_ready !== 8'h04) begin
      errors++;
      $display("FAIL single_rdy got %h exp 04", bus.in_ready);
    end
    clear_got();
    for (int n = 0; n < 8 && act[2]; n++) begin
      checks++;
      if (bus.arb_req !== 8'h00) begin
        errors++;
        $display("FAIL single_xfer_req got %h exp 00", bus.arb_req);
      end
      tick();
    end
    run_until_done(2);
    checks++;
    if (got_d.size() != 4) begin
      errors++;
      $display("FAIL single_count got %0d exp 4", got_d.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got_d[i] !== 8'h10 + 8'(i) || got_s[i] !== 3'd2 ||
            got_l[i] !== (i == 3)) begin
          errors++;
          $display("FAIL single_beat%0d got %h/%0d/%b exp %h/2/%b",
                   i, got_d[i], got_s[i], got_l[i], 8'h10 + 8'(i), i == 3);
        end
        if (i > 0) begin
          checks++;
          if (got_c[i] != got_c[i-1] + 1) begin
            errors++;
            $display("FAIL single_gap%0d got %0d exp %0d",
                     i, got_c[i], got_c[i-1] + 1);
          end
        end
      end
    end
  endtask

  task automatic test_no_interleave();
    int ord [4] = '{0, 2, 5, 7};
    logic [7:0] mask;
    for (int k = 0; k < 4; k++)
      start_pkt(ord[k], 3, 8'h80 + 8'(ord[k] * 16));
    drive_up();
    #1;
    clear_got();
    for (int k = 0; k < 4; k++) begin
      mask = '0;
      for (int c = 0; c < RW; c++) mask[c] = act[c];
      checks++;
      if (bus.arb_req !== mask) begin
        errors++;
        $display("FAIL ni_req%0d got %h exp %h", k, bus.arb_req, mask);
      end
      grant(ord[k], 8'(1 << ord[k]));
      run_until_done(ord[k]);
    end
    checks++;
    if (got_d.size() != 12) begin
      errors++;
      $display("FAIL ni_count got %0d exp 12", got_d.size());
    end else begin
      for (int i = 0; i < 12; i++) begin
        logic [7:0] ed;
        ed = 8'h80 + 8'(ord[i/3] * 16 + i % 3);
        checks++;
        if (got_d[i] !== ed || got_s[i] !== 3'(ord[i/3]) ||
            got_l[i] !== (i % 3 == 2)) begin
          errors++;
          $display("FAIL ni_beat%0d got %h/%0d/%b exp %h/%0d/%b",
                   i, got_d[i], got_s[i], got_l[i],
                   ed, ord[i/3], i % 3 == 2);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    start_pkt(1, 6, 8'h40);
    drive_up();
    #1;
    grant(1, 8'h02);
    clear_got();
    tick();
    tick();
    bus.out_ready = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.in_ready !== 8'h00) begin
        errors++;
        $display("FAIL bp_rdy%0d got %h exp 00", i, bus.in_ready);
      end
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h41) begin
        errors++;
        $display("FAIL bp_hold%0d got %b/%h exp 1/41",
                 i, bus.out_valid, bus.out_data);
      end
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    run_until_done(1);
    checks++;
    if (got_d.size() != 6) begin
      errors++;
      $display("FAIL bp_count got %0d exp 6", got_d.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (got_d[i] !== 8'h40 + 8'(i) || got_l[i] !== (i == 5)) begin
          errors++;
          $display("FAIL bp_beat%0d got %h/%b exp %h/%b",
                   i, got_d[i], got_l[i], 8'h40 + 8'(i), i == 5);
        end
      end
    end
  endtask

  task automatic test_bad_grant();
    start_pkt(3, 1, 8'h33);
    drive_up();
    #1;
    checks++;
    if (bus.err !== 1'b0) begin
      errors++;
      $display("FAIL bg_pre got %b exp 0", bus.err);
    end
    grant(3, 8'h10);
    checks++;
    if (bus.err !== 1'b1) begin
      errors++;
      $display("FAIL bg_set got %b exp 1", bus.err);
    end
    clear_got();
    run_until_done(3);
    checks++;
    if (bus.err !== 1'b1) begin
      errors++;
      $display("FAIL bg_sticky got %b exp 1", bus.err);
    end
    checks++;
    if (got_d.size() != 1 || got_d[0] !== 8'h33 || got_s[0] !== 3'd3) begin
      errors++;
      $display("FAIL bg_beat got n=%0d exp 1 beat 33 from 3", got_d.size());
    end
    do_reset();
    checks++;
    if (bus.err !== 1'b0) begin
      errors++;
      $display("FAIL bg_clr got %b exp 0", bus.err);
    end
  endtask

  task automatic test_ignored_ack();
    grant(4, 8'h10);
    checks++;
    if (bus.err !== 1'b1) begin
      errors++;
      $display("FAIL ig_err got %b exp 1", bus.err);
    end
    start_pkt(6, 1, 8'h66);
    drive_up();
    #1;
    checks++;
    if (bus.arb_req !== 8'h40 || bus.in_ready !== 8'h00) begin
      errors++;
      $display("FAIL ig_idle got %h/%h exp 40/00", bus.arb_req, bus.in_ready);
    end
    clear_got();
    grant(6, 8'h40);
    run_until_done(6);
    checks++;
    if (got_d.size() != 1 || got_d[0] !== 8'h66 || got_s[0] !== 3'd6) begin
      errors++;
      $display("FAIL ig_beat got n=%0d exp 1 beat 66 from 6", got_d.size());
    end
    do_reset();
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp_d [3] = '{8'h60, 8'h62, 8'h63};
    start_pkt(5, 4, 8'h60);
    drive_up();
    #1;
    grant(5, 8'h20);
    clear_got();
    tick();
    tick();
    bus.out_ready = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 8'h00) begin
      errors++;
      $display("FAIL rm_rdy got %h exp 00", bus.in_ready);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rm_drop got %b exp 0", bus.out_valid);
    end
    rst = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.arb_req !== 8'h20 || bidx[5] != 2) begin
      errors++;
      $display("FAIL rm_rereq got %h/%0d exp 20/2", bus.arb_req, bidx[5]);
    end
    grant(5, 8'h20);
    run_until_done(5);
    checks++;
    if (got_d.size() != 3) begin
      errors++;
      $display("FAIL rm_count got %0d exp 3", got_d.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got_d[i] !== exp_d[i] || got_s[i] !== 3'd5 ||
            got_l[i] !== (i == 2)) begin
          errors++;
          $display("FAIL rm_beat%0d got %h/%0d/%b exp %h/5/%b",
                   i, got_d[i], got_s[i], got_l[i], exp_d[i], i == 2);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    bus.in_valid  = '0;
    bus.in_data   = '0;
    bus.in_last   = '0;
    bus.arb_ack   = 1'b0;
    bus.arb_bin   = '0;
    bus.arb_hot   = '0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < RW; c++) begin
      act[c]   = 1'b0;
      bidx[c]  = 0;
      plen[c]  = 1;
      pbase[c] = 8'h00;
    end
    test_reset();
    test_single();
    test_no_interleave();
    test_backpressure();
    test_bad_grant();
    test_ignored_ack();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
